// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO result registers.
// One shift-add or restoring-divide step per cycle, followed by sign fix-up.
module mips_muldiv_unit #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned CNT_BITS = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wr_data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int unsigned W2 = 2 * WIDTH;

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} stateT;

   stateT               state, stateNext;
   logic [CNT_BITS-1:0] cnt, cntNext;
   logic [W2-1:0]       acc, accNext;
   logic [WIDTH-1:0]    operand, operandNext;
   logic                isDiv, isDivNext;
   logic                negRes, negResNext;
   logic                negRem, negRemNext;
   logic                divZero, divZeroNext;
   logic [WIDTH-1:0]    hiNext, loNext;
   logic                busyNext, doneNext;

   logic [WIDTH-1:0]    aMag, bMag, quot, rem;
   logic [WIDTH:0]      sum, cand, diff;

   // State and result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         acc     <= '0;
         operand <= '0;
         isDiv   <= 1'b0;
         negRes  <= 1'b0;
         negRem  <= 1'b0;
         divZero <= 1'b0;
         HI      <= '0;
         LO      <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= stateNext;
         cnt     <= cntNext;
         acc     <= accNext;
         operand <= operandNext;
         isDiv   <= isDivNext;
         negRes  <= negResNext;
         negRem  <= negRemNext;
         divZero <= divZeroNext;
         HI      <= hiNext;
         LO      <= loNext;
         busy    <= busyNext;
         done    <= doneNext;
      end
   end

   // Next-state, datapath step and output values
   always_comb begin
      stateNext   = state;
      cntNext     = cnt;
      accNext     = acc;
      operandNext = operand;
      isDivNext   = isDiv;
      negResNext  = negRes;
      negRemNext  = negRem;
      divZeroNext = divZero;
      hiNext      = HI;
      loNext      = LO;
      busyNext    = busy;
      doneNext    = 1'b0;

      aMag = (!op[0] && A[WIDTH-1]) ? -A : A;
      bMag = (!op[0] && B[WIDTH-1]) ? -B : B;
      sum  = {1'b0, acc[W2-1:WIDTH]} + {1'b0, (acc[0] ? operand : WIDTH'(0))};
      cand = acc[W2-1:WIDTH-1];
      diff = cand - {1'b0, operand};
      quot = acc[WIDTH-1:0];
      rem  = acc[W2-1:WIDTH];

      unique case (state)
         IDLE: begin
            if (start) begin
               isDivNext   = op[1];
               negResNext  = !op[0] && (A[WIDTH-1] ^ B[WIDTH-1]);
               negRemNext  = !op[0] && A[WIDTH-1];
               divZeroNext = (B == '0);
               operandNext = op[1] ? bMag : aMag;
               accNext     = {WIDTH'(0), (op[1] ? aMag : bMag)};
               cntNext     = CNT_BITS'(WIDTH);
               busyNext    = 1'b1;
               stateNext   = RUN;
            end else begin
               if (wr_hi) hiNext = wr_data;
               if (wr_lo) loNext = wr_data;
            end
         end
         RUN: begin
            // Divide keeps {remainder, quotient}; multiply keeps {partial, multiplier}
            if (isDiv) begin
               if (!diff[WIDTH]) accNext = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
               else              accNext = {cand[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end else begin
               accNext = {sum, acc[WIDTH-1:1]};
            end
            cntNext = cnt - CNT_BITS'(1);
            if (cnt == CNT_BITS'(1)) stateNext = FIX;
         end
         FIX: begin
            if (isDiv) begin
               if (divZero)     quot = '1;
               else if (negRes) quot = -quot;
               if (negRem)      rem  = -rem;
               accNext = {rem, quot};
            end else if (negRes) begin
               accNext = -acc;
            end
            stateNext = DONE;
         end
         DONE: begin
            hiNext    = acc[W2-1:WIDTH];
            loNext    = acc[WIDTH-1:0];
            doneNext  = 1'b1;
            busyNext  = 1'b0;
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit at WIDTH=32 and WIDTH=8.
module tb_mips_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start32, wrHi, wrLo;
   logic [1:0]  op32;
   logic [31:0] a32, b32, wrData;
   logic        busy32, done32;
   logic [31:0] hi32, lo32;

   logic        start8, wrHi8, wrLo8;
   logic [1:0]  op8;
   logic [7:0]  a8, b8, wrData8;
   logic        busy8, done8;
   logic [7:0]  hi8, lo8;

   int vectors     = 0;
   int miscompares = 0;
   int lat, busyCnt;
   logic doneSeen;

   always #5 clk = ~clk;

   mips_muldiv_unit #(.WIDTH(32)) dut32 (
      .clk(clk), .reset(reset), .start(start32), .op(op32), .A(a32), .B(b32),
      .wr_hi(wrHi), .wr_lo(wrLo), .wr_data(wrData),
      .busy(busy32), .done(done32), .HI(hi32), .LO(lo32));

   mips_muldiv_unit #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .op(op8), .A(a8), .B(b8),
      .wr_hi(wrHi8), .wr_lo(wrLo8), .wr_data(wrData8),
      .busy(busy8), .done(done8), .HI(hi8), .LO(lo8));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Called #1 after the edge that sampled start; counts edges until done
   task automatic waitDone32(output int l, output int b);
      l = 0;
      b = busy32 ? 1 : 0;
      while (!done32 && l < 200) begin
         @(posedge clk); #1;
         l++;
         if (busy32) b++;
      end
   endtask

   task automatic go32(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int l, output int bc);
      op32 = o; a32 = a; b32 = b; start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
      waitDone32(l, bc);
   endtask

   task automatic go8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                      output int l);
      op8 = o; a8 = a; b8 = b; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      l = 0;
      while (!done8 && l < 200) begin
         @(posedge clk); #1;
         l++;
      end
   endtask

   initial begin
      reset = 1'b1; start32 = 1'b0; wrHi = 1'b0; wrLo = 1'b0; op32 = 2'd0;
      a32 = '0; b32 = '0; wrData = '0;
      start8 = 1'b0; wrHi8 = 1'b0; wrLo8 = 1'b0; op8 = 2'd0; a8 = '0; b8 = '0; wrData8 = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_hi", 64'(hi32), 64'h0);
      check("rst_lo", 64'(lo32), 64'h0);
      check("rst_busy", 64'(busy32), 64'h0);
      check("rst_done", 64'(done32), 64'h0);
      reset = 1'b0;
      @(posedge clk); #1;

      // MULTU all-ones squared
      go32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, busyCnt);
      check("multu_lat", 64'(lat), 64'd34);
      check("multu_busycycles", 64'(busyCnt), 64'd34);
      check("multu_busy_in_done", 64'(busy32), 64'h0);
      check("multu_hi", 64'(hi32), 64'hFFFF_FFFE);
      check("multu_lo", 64'(lo32), 64'h0000_0001);
      @(posedge clk); #1;
      check("done_one_cycle", 64'(done32), 64'h0);

      // MULT then back-to-back DIV
      go32(2'b00, 32'hFFFF_FFFD, 32'd7, lat, busyCnt);
      check("mult_hi", 64'(hi32), 64'hFFFF_FFFF);
      check("mult_lo", 64'(lo32), 64'hFFFF_FFEB);
      go32(2'b10, 32'hFFFF_FFF9, 32'd2, lat, busyCnt);
      check("b2b_div_lat", 64'(lat), 64'd34);
      check("div_lo", 64'(lo32), 64'hFFFF_FFFD);
      check("div_hi", 64'(hi32), 64'hFFFF_FFFF);

      // Divide-by-zero and signed overflow
      go32(2'b11, 32'd100, 32'd0, lat, busyCnt);
      check("divu0_lat", 64'(lat), 64'd34);
      check("divu0_lo", 64'(lo32), 64'hFFFF_FFFF);
      check("divu0_hi", 64'(hi32), 64'h0000_0064);
      go32(2'b10, 32'hFFFF_FFFB, 32'd0, lat, busyCnt);
      check("div0_lo", 64'(lo32), 64'hFFFF_FFFF);
      check("div0_hi", 64'(hi32), 64'hFFFF_FFFB);
      go32(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, busyCnt);
      check("divovf_lo", 64'(lo32), 64'h8000_0000);
      check("divovf_hi", 64'(hi32), 64'h0);

      // start and MTLO during an operation are dropped
      op32 = 2'b01; a32 = 32'd5; b32 = 32'd6; start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      start32 = 1'b1; op32 = 2'b11; a32 = 32'd9; b32 = 32'd3;
      wrLo = 1'b1; wrData = 32'h1234;
      @(posedge clk); #1;
      start32 = 1'b0; wrLo = 1'b0;
      check("busy_mid", 64'(busy32), 64'h1);
      waitDone32(lat, busyCnt);
      check("ignored_lat", 64'(lat + 10), 64'd34);
      check("ignored_hi", 64'(hi32), 64'h0);
      check("ignored_lo", 64'(lo32), 64'd30);
      @(posedge clk); #1;

      // MTHI in IDLE
      wrHi = 1'b1; wrData = 32'h0000_ABCD;
      @(posedge clk); #1;
      wrHi = 1'b0;
      check("mthi_hi", 64'(hi32), 64'h0000_ABCD);
      check("mthi_lo", 64'(lo32), 64'd30);

      // start wins over MTHI
      op32 = 2'b01; a32 = 32'd2; b32 = 32'd2; start32 = 1'b1;
      wrHi = 1'b1; wrData = 32'h5555;
      @(posedge clk); #1;
      start32 = 1'b0; wrHi = 1'b0;
      check("start_mthi_hi", 64'(hi32), 64'h0000_ABCD);
      check("start_mthi_busy", 64'(busy32), 64'h1);
      waitDone32(lat, busyCnt);
      check("start_mthi_lat", 64'(lat), 64'd34);
      check("start_mthi_res_hi", 64'(hi32), 64'h0);
      check("start_mthi_res_lo", 64'(lo32), 64'd4);
      @(posedge clk); #1;

      // Reset mid-DIVU clears HI/LO and suppresses done
      wrHi = 1'b1; wrData = 32'h77;
      @(posedge clk); #1;
      wrHi = 1'b0;
      op32 = 2'b11; a32 = 32'd1000; b32 = 32'd7; start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
      repeat (14) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort_busy", 64'(busy32), 64'h0);
      check("abort_hi", 64'(hi32), 64'h0);
      check("abort_lo", 64'(lo32), 64'h0);
      doneSeen = done32;
      repeat (40) begin @(posedge clk); #1; doneSeen = doneSeen | done32; end
      check("abort_no_done", 64'(doneSeen), 64'h0);
      go32(2'b01, 32'd2, 32'd3, lat, busyCnt);
      check("after_rst_lat", 64'(lat), 64'd34);
      check("after_rst_lo", 64'(lo32), 64'd6);
      check("after_rst_hi", 64'(hi32), 64'h0);

      // WIDTH=8 instance
      go8(2'b00, 8'h80, 8'hFF, lat);
      check("w8_mult_lat", 64'(lat), 64'd10);
      check("w8_mult_hi", 64'(hi8), 64'h00);
      check("w8_mult_lo", 64'(lo8), 64'h80);
      go8(2'b01, 8'hFF, 8'hFF, lat);
      check("w8_multu_hi", 64'(hi8), 64'hFE);
      check("w8_multu_lo", 64'(lo8), 64'h01);
      go8(2'b10, 8'hF9, 8'h02, lat);
      check("w8_div_lat", 64'(lat), 64'd10);
      check("w8_div_lo", 64'(lo8), 64'hFD);
      check("w8_div_hi", 64'(hi8), 64'hFF);
      go8(2'b10, 8'h80, 8'hFF, lat);
      check("w8_divovf_lo", 64'(lo8), 64'h80);
      check("w8_divovf_hi", 64'(hi8), 64'h00);
      go8(2'b11, 8'd100, 8'd0, lat);
      check("w8_divu0_lo", 64'(lo8), 64'hFF);
      check("w8_divu0_hi", 64'(hi8), 64'h64);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
